// File: rtl/key_rec_j_if.sv
// Lane J chart recorder bus: frame/key/record controls in, read window and status out.
interface key_rec_j_if;
  logic        frame_tick;
  logic        rec_en;
  logic        key_in;
  logic [7:0]  addr;
  logic [15:0] key_1;
  logic [15:0] key_2;
  logic [15:0] key_3;
  logic [15:0] key_4;
  logic [8:0]  count;
  logic        recording;
  logic        overflow;

  modport master (
    output frame_tick, rec_en, key_in, addr,
    input  key_1, key_2, key_3, key_4, count, recording, overflow
  );

  modport slave (
    input  frame_tick, rec_en, key_in, addr,
    output key_1, key_2, key_3, key_4, count, recording, overflow
  );
endinterface

// File: rtl/key_rec_j.sv
// Lane J chart recorder: samples the key once per frame, encodes taps/holds into
// 16-bit chart entries in a 256-entry buffer, read back through a 4-word window.
module key_rec_j #(
  parameter int unsigned HOLD_MIN = 12
) (
  input logic        clk,
  input logic        rst,
  key_rec_j_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, PRESSED, HOLDING} state_e;

  localparam int unsigned WIN = 4;

  state_e                  state_q, state_d;
  logic                    rec_dly_q, rec_dly_d;
  logic                    key_prev_q, key_prev_d;
  logic [13:0]             frame_cnt_q, frame_cnt_d;
  logic [13:0]             press_time_q, press_time_d;
  logic [8:0]              count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [WIN-1:0][15:0]    win_q, win_d;
  logic [15:0]             buf_q [256];

  logic                    rise, fall;
  logic                    wr_req, wr_en;
  logic [15:0]             wr_data;
  logic [13:0]             held;

  assign rise = bus.rec_en & ~rec_dly_q;
  assign fall = ~bus.rec_en & rec_dly_q;
  assign held = frame_cnt_q - press_time_q;

  always_comb begin
    state_d      = state_q;
    rec_dly_d    = bus.rec_en;
    key_prev_d   = key_prev_q;
    frame_cnt_d  = frame_cnt_q;
    press_time_d = press_time_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    wr_req       = 1'b0;
    wr_data      = '0;

    if (bus.frame_tick) key_prev_d = bus.key_in;

    if (rise) begin
      count_d     = '0;
      frame_cnt_d = '0;
      ovf_d       = 1'b0;
      key_prev_d  = bus.key_in;
      state_d     = WAIT;
    end else if (fall && state_q != IDLE) begin
      // Stop closes any open press; the tick in this cycle is discarded.
      case (state_q)
        PRESSED: begin wr_req = 1'b1; wr_data = {2'b00, press_time_q}; end
        HOLDING: begin wr_req = 1'b1; wr_data = {2'b10, frame_cnt_q}; end
        default: ;
      endcase
      state_d = IDLE;
    end else if (bus.frame_tick && state_q != IDLE) begin
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 14'd1;
      case (state_q)
        WAIT: begin
          if (bus.key_in && !key_prev_q) begin
            press_time_d = frame_cnt_q;
            state_d      = PRESSED;
          end
        end
        PRESSED: begin
          if (!bus.key_in) begin
            wr_req  = 1'b1;
            wr_data = {2'b00, press_time_q};
            state_d = WAIT;
          end else if (held == 14'(HOLD_MIN)) begin
            wr_req  = 1'b1;
            wr_data = {2'b01, press_time_q};
            state_d = HOLDING;
          end
        end
        HOLDING: begin
          if (!bus.key_in) begin
            wr_req  = 1'b1;
            wr_data = {2'b10, frame_cnt_q};
            state_d = WAIT;
          end
        end
        default: ;
      endcase
    end

    // A full buffer drops the entry; count never wraps past 256.
    if (wr_req) begin
      if (count_q[8]) ovf_d   = 1'b1;
      else            count_d = count_q + 9'd1;
    end
  end

  assign wr_en = wr_req & ~count_q[8];

  for (genvar g = 0; g < WIN; g++) begin : g_win
    logic [7:0] idx;
    assign idx      = bus.addr + 8'(g);
    assign win_d[g] = (9'(idx) < count_q) ? buf_q[idx] : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rec_dly_q    <= 1'b0;
      key_prev_q   <= 1'b0;
      frame_cnt_q  <= '0;
      press_time_q <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      win_q        <= '0;
    end else begin
      state_q      <= state_d;
      rec_dly_q    <= rec_dly_d;
      key_prev_q   <= key_prev_d;
      frame_cnt_q  <= frame_cnt_d;
      press_time_q <= press_time_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      win_q        <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[count_q[7:0]] <= wr_data;
  end

  assign bus.key_1     = win_q[0];
  assign bus.key_2     = win_q[1];
  assign bus.key_3     = win_q[2];
  assign bus.key_4     = win_q[3];
  assign bus.count     = count_q;
  assign bus.recording = (state_q != IDLE);
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_key_rec_j.sv
// Bench for key_rec_j: directed chart scenarios plus random recordings, every cycle
// compared against a press/hold reference model of the chart format.
module tb_key_rec_j;
  localparam int HM = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_rec_j_if bus();
  key_rec_j #(.HOLD_MIN(HM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: a recording session, the frame of the open press (-1 = none)
  // and whether its hold-start entry has been emitted.
  bit          m_rec_d, m_act, m_prev, m_hold, m_ovf;
  int          m_fc, m_press, m_count;
  logic [15:0] m_buf [256];
  logic [15:0] e_key [4];
  bit          rec;

  task automatic model_reset();
    m_rec_d = 0; m_act = 0; m_prev = 0; m_hold = 0; m_ovf = 0;
    m_fc = 0; m_press = -1; m_count = 0;
    for (int i = 0; i < 4; i++) e_key[i] = '0;
  endtask

  task automatic emit(input logic [15:0] e);
    if (m_count == 256) m_ovf = 1;
    else begin m_buf[m_count] = e; m_count++; end
  endtask

  task automatic model_step(input bit tk, input bit r, input bit key, input logic [7:0] a);
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = (int'(a) + i) % 256;
      e_key[i] = (idx < m_count) ? m_buf[idx] : 16'h0000;
    end
    if (r && !m_rec_d) begin
      m_count = 0; m_fc = 0; m_ovf = 0; m_prev = key;
      m_act = 1; m_press = -1; m_hold = 0;
    end else if (!r && m_rec_d && m_act) begin
      if (m_press >= 0) emit(m_hold ? {2'b10, 14'(m_fc)} : {2'b00, 14'(m_press)});
      m_act = 0; m_press = -1; m_hold = 0;
    end else if (tk && m_act) begin
      if (m_press < 0) begin
        if (key && !m_prev) m_press = m_fc;
      end else if (!m_hold) begin
        if (!key) begin emit({2'b00, 14'(m_press)}); m_press = -1; end
        else if (((m_fc - m_press) & 16'h3FFF) == HM) begin
          emit({2'b01, 14'(m_press)}); m_hold = 1;
        end
      end else if (!key) begin
        emit({2'b10, 14'(m_fc)}); m_press = -1; m_hold = 0;
      end
      if (m_fc < 16383) m_fc++;
    end
    if (tk) m_prev = key;
    m_rec_d = r;
  endtask

  task automatic cyc(input bit tk, input bit key, input logic [7:0] a);
    bus.frame_tick = tk; bus.key_in = key; bus.addr = a; bus.rec_en = rec;
    model_step(tk, rec, key, a);
    @(posedge clk); #1;
    chk("key_1", bus.key_1, e_key[0]);
    chk("key_2", bus.key_2, e_key[1]);
    chk("key_3", bus.key_3, e_key[2]);
    chk("key_4", bus.key_4, e_key[3]);
    chk("count", bus.count, m_count);
    chk("recording", bus.recording, m_act);
    chk("overflow", bus.overflow, m_ovf);
  endtask

  task automatic frame(input bit key, input logic [7:0] a);
    cyc(1, key, a);
    cyc(0, key, a);
  endtask

  task automatic start_rec(); rec = 1; cyc(0, 0, 0); endtask
  task automatic stop_rec();  rec = 0; cyc(0, 0, 0); endtask

  initial begin
    bit k;
    int n;
    rst = 1; rec = 0;
    bus.frame_tick = 0; bus.rec_en = 0; bus.key_in = 0; bus.addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_recording", bus.recording, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_key_1", bus.key_1, 0);
    rst = 0;

    // Tap: press at 50, release at 55
    start_rec();
    for (int t = 0; t < 60; t++) frame(t >= 50 && t < 55, 0);
    cyc(0, 0, 0);
    chk("tap_key_1", bus.key_1, 16'h0032);
    chk("tap_count", bus.count, 1);
    stop_rec();

    // Held exactly HOLD_MIN frames is still a tap
    start_rec();
    for (int t = 0; t < 25; t++) frame(t >= 10 && t < 22, 0);
    cyc(0, 0, 0);
    chk("bnd_tap", bus.key_1, 16'h000A);
    chk("bnd_tap_count", bus.count, 1);
    stop_rec();

    // One frame longer becomes a hold; also window past count reads zero
    start_rec();
    for (int t = 0; t < 26; t++) frame(t >= 10 && t < 23, 0);
    cyc(0, 0, 1);
    chk("bnd_hold_end", bus.key_1, 16'h8017);
    chk("win_k2_zero", bus.key_2, 16'h0000);
    chk("win_k4_zero", bus.key_4, 16'h0000);
    cyc(0, 0, 0);
    chk("bnd_hold_start", bus.key_1, 16'h400A);
    stop_rec();

    // Stop mid-hold at frame_cnt 140; later ticks/presses ignored
    start_rec();
    for (int t = 0; t < 140; t++) frame(t >= 100, 0);
    rec = 0;
    cyc(1, 1, 0);
    for (int t = 0; t < 20; t++) frame(t[1], 1);
    cyc(0, 0, 0);
    chk("stop_hold_start", bus.key_1, 16'h4064);
    chk("stop_hold_end", bus.key_2, 16'h808C);
    chk("stop_count", bus.count, 2);
    chk("stop_idle", bus.recording, 0);

    // Random recordings, one of them cut by an asynchronous reset
    for (int r = 0; r < 6; r++) begin
      start_rec();
      k = 0;
      n = $urandom_range(30, 120);
      for (int t = 0; t < n; t++) begin
        if ($urandom_range(0, 3) == 0) k = ~k;
        if ($urandom_range(0, 4) == 0) cyc(0, k, 8'($urandom_range(0, 255)));
        frame(k, 8'($urandom_range(0, 7)));
      end
      if (r == 3) begin
        rst = 1; #1;
        model_reset();
        chk("midrst_count", bus.count, 0);
        chk("midrst_recording", bus.recording, 0);
        chk("midrst_key_1", bus.key_1, 0);
        rst = 0;
        for (int t = 0; t < 10; t++) frame(t[0], 0);
        chk("midrst_restart_count", bus.count, m_count);
      end
      if (k) frame(1, 0);
      stop_rec();
    end

    // Full buffer: 257 taps at odd frames
    start_rec();
    frame(0, 0);
    for (int i = 0; i < 257; i++) begin frame(1, 0); frame(0, 0); end
    cyc(0, 0, 255);
    chk("full_count", bus.count, 256);
    chk("full_overflow", bus.overflow, 1);
    chk("full_entry255", bus.key_1, 16'h01FF);
    cyc(0, 0, 254);
    chk("wrap_k1", bus.key_1, 16'h01FD);
    chk("wrap_k2", bus.key_2, 16'h01FF);
    chk("wrap_k3", bus.key_3, 16'h0001);
    chk("wrap_k4", bus.key_4, 16'h0003);
    stop_rec();
    start_rec();
    chk("restart_count", bus.count, 0);
    chk("restart_overflow", bus.overflow, 0);
    stop_rec();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/key_rec_j.md
# key_rec_j

Chart recorder for lane J: samples the player's lane key once per video frame while recording is enabled. Encodes each press/release into the 16-bit chart-entry format the lane key ROMs use: bits [15:14] type (00 tap, 01 hold start, 10 hold end), bits [13:0] timestamp in frames. Entries go into a 256-entry buffer. The buffer is read back through the same 4-word sliding window the chart ROMs expose, so a recorded chart drops into the note-scheduling path unchanged.

## Interface
- HOLD_MIN, 12: press duration in frames above which a press is a hold instead of a tap (1..255)
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high; clears all state
- frame_tick  in  1  one-cycle pulse per video frame (60 Hz)
- rec_en  in  1  level; rising edge starts a new recording, falling edge ends it
- key_in  in  1  debounced lane key level, 1 = pressed
- addr  in  8  read window base index
- key_1..key_4  out  16 each  entries at addr, addr+1, addr+2, addr+3 (mod 256), registered
- count  out  9  number of valid entries, 0..256
- recording  out  1  high while in any state other than IDLE
- overflow  out  1  sticky; a write was dropped because the buffer was full

## Operation
- Reset: all outputs 0, state IDLE, frame_cnt = 0, press_time = 0, key_prev = 0. Buffer contents are don't-care, masked by count.
- rec_en rising edge (registered rec_en_d = 0, rec_en = 1):
  - count, frame_cnt and overflow clear
  - key_prev ← key_in
  - go to WAIT
- frame_cnt: 14-bit; +1 on each frame_tick while recording; saturates at 16383.
- Event timestamp = frame_cnt value in the tick cycle, before increment.
- Key edges are evaluated only on frame_tick cycles, comparing key_in with key_prev; key_prev updates on every tick.
- States:
  - IDLE: ignore ticks. Go to WAIT on rec_en rising edge.
  - WAIT: on a tick with a 0→1 key edge, press_time ← ts, go to PRESSED. No write.
  - PRESSED, on a tick with key_in = 0: write {00, press_time}, go to WAIT.
  - PRESSED, on a tick with key_in = 1 and ts − press_time == HOLD_MIN: write {01, press_time}, go to HOLDING.
  - HOLDING: on a tick with key_in = 0, write {10, ts}, go to WAIT.
- Stop (rec_en falling edge): checked before tick processing, and the tick in that cycle is ignored.
  - PRESSED: write {00, press_time}
  - HOLDING: write {10, frame_cnt}
  - always go to IDLE
- Rising edge while not IDLE: not possible, since rec_en would have to fall first.
- Write rule: at most one write per cycle, to buffer[count[7:0]], then count+1.
  - If count == 256, the write is dropped and overflow ← 1.
  - count never wraps.
- Tap rule: a press lasting ≤ HOLD_MIN frames is a tap. A press lasting > HOLD_MIN frames produces the 01 entry at the HOLD_MIN tick, then the 10 entry at release.
- Read: key_n ← (addr+n−1 mod 256) < count ? buffer[addr+n−1] : 16'h0000. Index wraps modulo 256; the valid check uses the wrapped index.

## Timing
- Write committed on the tick/stop edge. count updates on the same edge.
- Read latency: 1 cycle from addr to key_1..key_4.
- An entry written at edge N is visible on key_x after edge N+1 when addressed.
- recording rises one cycle after rec_en rises and falls one cycle after rec_en falls.
- Reset mid-recording: immediate return to IDLE with count = 0. The pending press is discarded and no entry is written.
- key_in changes between ticks are invisible; a press shorter than one frame may be missed.

## Test plan
- Tap: start, press at tick 50, release at tick 55 (HOLD_MIN = 12) → one entry 16'h0032, count = 1, key_1 = 16'h0032 at addr = 0.
- Hold: press at tick 556, release at tick 565 with HOLD_MIN = 3 → entry 16'h422C written at tick 559, then 16'h8235 written at tick 565, count = 2.
- Boundary: press held exactly HOLD_MIN = 12 frames (ticks 10..22) → tap 16'h000A; held 13 frames → 16'h400A then 16'h8017.
- Stop mid-hold: hold started at 100 (01 entry written), rec_en falls at frame_cnt 140 → 16'h808C written, state IDLE, subsequent ticks and presses are ignored.
- Full buffer: record 257 taps → count = 256, overflow = 1, entry 255 intact. A new rec_en rising edge clears count and overflow.
- Window wrap: count = 256, addr = 254 → key_1 = buf[254], key_2 = buf[255], key_3 = buf[0], key_4 = buf[1]. With count = 2 and addr = 1 → key_2..key_4 = 0.
